// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pipeline_hazard_ctrl_if : hazard sources in, stage controls out             |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       ex_rd;
   logic             ex_mem_read;
   logic [2:0]       ex_npc_op;
   logic             ex_int_req;
   logic             ex_mdu_start;
   logic             mdu_done;
   logic             mem_req;
   logic             dmem_ready;
   logic             pc_write;
   logic             pc_sel_trap;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_write;
   logic             id_ex_flush;
   logic             ex_mem_write;
   logic             ex_mem_flush;
   logic             mem_wb_flush;
   logic             int_ack;
   logic             mem_fault;
   logic [CNT_W-1:0] stall_cycles;

   // master = pipeline side, slave = the hazard controller
   modport master (
      output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_npc_op, ex_int_req,
             ex_mdu_start, mdu_done, mem_req, dmem_ready,
      input  pc_write, pc_sel_trap, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_flush,
             int_ack, mem_fault, stall_cycles
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_npc_op, ex_int_req,
             ex_mdu_start, mdu_done, mem_req, dmem_ready,
      output pc_write, pc_sel_trap, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, ex_mem_flush, mem_wb_flush,
             int_ack, mem_fault, stall_cycles
   );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | pipeline_hazard_ctrl : stall/flush scheduler for the 5-stage pipeline       |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
   parameter int unsigned INT_DRAIN_CYCLES = 2,
   parameter int unsigned MEM_TIMEOUT      = 64,
   parameter int unsigned CNT_W            = 32
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int unsigned TMO_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMO_W:0] c_TMO_LIM    = MEM_TIMEOUT[TMO_W:0];
   localparam logic [3:0]     c_DRAIN_LAST = INT_DRAIN_CYCLES[3:0];

   typedef enum logic [1:0] {
      S_RUN       = 2'd0,
      S_MEM_WAIT  = 2'd1,
      S_MDU_WAIT  = 2'd2,
      S_INT_ENTER = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
   logic [TMO_W:0]   w_tmo_inc;
   logic [3:0]       r_drain, w_drain_nxt;
   logic [CNT_W-1:0] r_stall;
   logic             w_run_rules, w_mask_mdu, w_load_use;
   logic             w_pc_write, w_pc_sel_trap, w_if_id_write, w_if_id_flush;
   logic             w_id_ex_write, w_id_ex_flush, w_ex_mem_write, w_ex_mem_flush;
   logic             w_mem_wb_flush, w_int_ack, w_mem_fault;

   assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                       ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
   assign w_tmo_inc  = {1'b0, r_tmo} + (TMO_W + 1)'(1);

   always_comb begin
      w_pc_write     = 1'b1;
      w_pc_sel_trap  = 1'b0;
      w_if_id_write  = 1'b1;
      w_if_id_flush  = 1'b0;
      w_id_ex_write  = 1'b1;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_write = 1'b1;
      w_ex_mem_flush = 1'b0;
      w_mem_wb_flush = 1'b0;
      w_int_ack      = 1'b0;
      w_mem_fault    = 1'b0;
      w_state_nxt    = r_state;
      w_tmo_nxt      = r_tmo;
      w_drain_nxt    = r_drain;
      w_run_rules    = 1'b0;
      w_mask_mdu     = 1'b0;

      case (r_state)
         S_RUN: w_run_rules = 1'b1;
         S_MEM_WAIT: begin
            // A ready memory hands the cycle back to the normal rules; rule 1 cannot fire then.
            if (hz.dmem_ready) begin
               w_run_rules = 1'b1;
            end else if ((MEM_TIMEOUT != 0) && (w_tmo_inc >= c_TMO_LIM)) begin
               w_mem_fault = 1'b1;
               w_state_nxt = S_RUN;
            end else begin
               w_pc_write     = 1'b0;
               w_if_id_write  = 1'b0;
               w_id_ex_write  = 1'b0;
               w_ex_mem_write = 1'b0;
               w_mem_wb_flush = 1'b1;
               w_tmo_nxt      = w_tmo_inc[TMO_W-1:0];
            end
         end
         S_MDU_WAIT: begin
            if (hz.mdu_done) begin
               w_run_rules = 1'b1;
               w_mask_mdu  = 1'b1;
            end else begin
               w_pc_write     = 1'b0;
               w_if_id_write  = 1'b0;
               w_id_ex_write  = 1'b0;
               w_ex_mem_write = 1'b0;
            end
         end
         S_INT_ENTER: begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            if (r_drain >= c_DRAIN_LAST) begin
               w_pc_sel_trap = 1'b1;
               w_int_ack     = 1'b1;
               w_state_nxt   = S_RUN;
            end else begin
               w_pc_write  = 1'b0;
               w_drain_nxt = r_drain + 4'd1;
            end
         end
         default: w_state_nxt = S_RUN;
      endcase

      if (w_run_rules) begin
         w_state_nxt = S_RUN;
         if (hz.mem_req && !hz.dmem_ready) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_mem_wb_flush = 1'b1;
            w_state_nxt    = S_MEM_WAIT;
            w_tmo_nxt      = TMO_W'(1);
         end else if (!w_mask_mdu && hz.ex_mdu_start) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
            w_ex_mem_flush = 1'b1;
            w_state_nxt    = S_MDU_WAIT;
         end else if (hz.ex_int_req) begin
            w_pc_write    = 1'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_state_nxt   = S_INT_ENTER;
            w_drain_nxt   = 4'd1;
         end else if (hz.ex_npc_op != 3'd0) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
         end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
         end
      end

      if (rst) begin
         w_pc_write     = 1'b0;
         w_pc_sel_trap  = 1'b0;
         w_if_id_write  = 1'b0;
         w_if_id_flush  = 1'b0;
         w_id_ex_write  = 1'b0;
         w_id_ex_flush  = 1'b0;
         w_ex_mem_write = 1'b0;
         w_ex_mem_flush = 1'b0;
         w_mem_wb_flush = 1'b0;
         w_int_ack      = 1'b0;
         w_mem_fault    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
         r_tmo   <= '0;
         r_drain <= '0;
         r_stall <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tmo   <= w_tmo_nxt;
         r_drain <= w_drain_nxt;
         if (!w_pc_write && (r_stall != {CNT_W{1'b1}}))
            r_stall <= r_stall + CNT_W'(1);
      end
   end

   assign hz.pc_write     = w_pc_write;
   assign hz.pc_sel_trap  = w_pc_sel_trap;
   assign hz.if_id_write  = w_if_id_write;
   assign hz.if_id_flush  = w_if_id_flush;
   assign hz.id_ex_write  = w_id_ex_write;
   assign hz.id_ex_flush  = w_id_ex_flush;
   assign hz.ex_mem_write = w_ex_mem_write;
   assign hz.ex_mem_flush = w_ex_mem_flush;
   assign hz.mem_wb_flush = w_mem_wb_flush;
   assign hz.int_ack      = w_int_ack;
   assign hz.mem_fault    = w_mem_fault;
   assign hz.stall_cycles = r_stall;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl : vector table, corner sequences, random vs model   |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;
   localparam int DRAIN = 2;
   localparam int TMO   = 4;
   localparam int CW    = 6;

   // {pc_write, pc_sel_trap, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
   //  ex_mem_write, ex_mem_flush, mem_wb_flush, int_ack, mem_fault}
   localparam logic [10:0] V_DEF  = 11'b1_0_1_0_1_0_1_0_0_0_0;
   localparam logic [10:0] V_MEM  = 11'b0_0_0_0_0_0_0_0_1_0_0;
   localparam logic [10:0] V_MDU  = 11'b0_0_0_0_0_0_0_1_0_0_0;
   localparam logic [10:0] V_MDUW = 11'b0_0_0_0_0_0_0_0_0_0_0;
   localparam logic [10:0] V_INT  = 11'b0_0_1_1_1_1_1_0_0_0_0;
   localparam logic [10:0] V_BR   = 11'b1_0_1_1_1_1_1_0_0_0_0;
   localparam logic [10:0] V_LU   = 11'b0_0_0_0_1_1_1_0_0_0_0;
   localparam logic [10:0] V_TRAP = 11'b1_1_1_1_1_1_1_0_0_1_0;
   localparam logic [10:0] V_FLT  = 11'b1_0_1_0_1_0_1_0_0_0_1;
   localparam logic [10:0] V_RST  = 11'b0_0_0_0_0_0_0_0_0_0_0;

   typedef struct packed {
      logic [4:0]  rs1, rs2, rd;
      logic        mread;
      logic [2:0]  npc;
      logic        intr, mdu, done, mreq, rdy;
      logic [10:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_err    = 0;

   // Model state: cycles already spent waiting on memory / in MDU wait / index of interrupt-entry cycle.
   int m_mem_waited = 0, m_int_cycle = 0, m_stall = 0;
   bit m_in_mdu = 1'b0;
   int nx_mem, nx_int, nx_stall;
   bit nx_mdu;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

   pipeline_hazard_ctrl #(
      .INT_DRAIN_CYCLES(DRAIN),
      .MEM_TIMEOUT     (TMO),
      .CNT_W           (CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (hz)
   );

   function automatic logic [10:0] dut_vec();
      return {hz.pc_write, hz.pc_sel_trap, hz.if_id_write, hz.if_id_flush,
              hz.id_ex_write, hz.id_ex_flush, hz.ex_mem_write, hz.ex_mem_flush,
              hz.mem_wb_flush, hz.int_ack, hz.mem_fault};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %b required %b (t=%0t)", name, got[10:0], want[10:0], $time);
      end
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mread, input logic [2:0] npc, input logic intr,
                         input logic mdu, input logic done, input logic mreq, input logic rdy);
      hz.id_rs1 = rs1;  hz.id_rs2 = rs2;  hz.ex_rd = rd;  hz.ex_mem_read = mread;
      hz.ex_npc_op = npc;  hz.ex_int_req = intr;  hz.ex_mdu_start = mdu;
      hz.mdu_done = done;  hz.mem_req = mreq;  hz.dmem_ready = rdy;
   endtask

   task automatic idle();
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic model_eval(output logic [10:0] e);
      bit lu;
      lu = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
           ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
      e = V_DEF;  nx_mem = 0;  nx_int = 0;  nx_mdu = 1'b0;  nx_stall = m_stall;
      if (rst) begin
         e = V_RST;  nx_stall = 0;
      end else if (m_int_cycle != 0) begin
         if (m_int_cycle == DRAIN + 1) e = V_TRAP;
         else begin e = V_INT;  nx_int = m_int_cycle + 1; end
      end else if (m_mem_waited != 0 && !hz.dmem_ready) begin
         if (TMO != 0 && m_mem_waited + 1 >= TMO) e = V_FLT;
         else begin e = V_MEM;  nx_mem = m_mem_waited + 1; end
      end else if (m_in_mdu && !hz.mdu_done) begin
         e = V_MDUW;  nx_mdu = 1'b1;
      end else begin
         if (hz.mem_req && !hz.dmem_ready) begin e = V_MEM;  nx_mem = 1; end
         else if (!m_in_mdu && hz.ex_mdu_start) begin e = V_MDU;  nx_mdu = 1'b1; end
         else if (hz.ex_int_req) begin e = V_INT;  nx_int = 2; end
         else if (hz.ex_npc_op != 3'd0) e = V_BR;
         else if (lu) e = V_LU;
      end
      if (!rst && !e[10]) nx_stall = (m_stall == (1 << CW) - 1) ? m_stall : m_stall + 1;
   endtask

   // One clock: check outputs mid-low-phase against the model (and a constant if given), then advance.
   task automatic step(input string name, input logic [10:0] want, input bit has_want);
      logic [10:0] e;
      #2;
      model_eval(e);
      chk({name, "/model"}, 32'(dut_vec()), 32'(e));
      chk({name, "/stall"}, 32'(hz.stall_cycles), m_stall);
      if (has_want) chk(name, 32'(dut_vec()), 32'(want));
      @(posedge clk);
      m_mem_waited = nx_mem;  m_int_cycle = nx_int;  m_in_mdu = nx_mdu;  m_stall = nx_stall;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;  idle();
      step("reset", V_RST, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [13];
      logic [31:0] r;
      //         rs1    rs2    rd     mrd   npc   int   mdu   done  mreq  rdy   expected
      vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF};
      vecs[1]  = '{5'd1, 5'd5, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_LU};
      vecs[2]  = '{5'd7, 5'd2, 5'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_LU};
      vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF};
      vecs[4]  = '{5'd3, 5'd5, 5'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_DEF};
      vecs[5]  = '{5'd3, 5'd5, 5'd5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_BR};
      vecs[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_BR};
      vecs[7]  = '{5'd0, 5'd5, 5'd5, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_INT};
      vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V_MDU};
      vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, V_MEM};
      vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_BR};
      vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_DEF};
      vecs[12] = '{5'd9, 5'd1, 5'd9, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_LU};

      rst = 1'b1;  idle();
      @(posedge clk);  @(negedge clk);
      do_reset();

      for (int i = 0; i < 13; i++) begin
         set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mread, vecs[i].npc,
                vecs[i].intr, vecs[i].mdu, vecs[i].done, vecs[i].mreq, vecs[i].rdy);
         step($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
         do_reset();
      end

      // Load-use stalls one cycle; ex_rd=0 never stalls.
      set_in(5'd0, 5'd5, 5'd5, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lu", V_LU, 1'b1);
      chk("lu_stall_cnt", 32'(hz.stall_cycles), 32'd1);
      set_in(5'd0, 5'd0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("lu_rd0", V_DEF, 1'b1);
      chk("lu_rd0_stall_cnt", 32'(hz.stall_cycles), 32'd1);

      // MDU: 1 start + 4 wait cycles frozen, release on done.
      do_reset();
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("mdu_start", V_MDU, 1'b1);
      for (int k = 0; k < 4; k++) step("mdu_wait", V_MDUW, 1'b1);
      hz.mdu_done = 1'b1;
      step("mdu_done", V_DEF, 1'b1);
      idle();
      step("mdu_after", V_DEF, 1'b1);
      chk("mdu_stall_cnt", 32'(hz.stall_cycles), 32'd5);

      // Interrupt raised during MDU wait is deferred until the done cycle.
      do_reset();
      set_in(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step("mdui_start", V_MDU, 1'b1);
      step("mdui_wait", V_MDUW, 1'b1);
      hz.ex_int_req = 1'b1;
      for (int k = 0; k < 3; k++) step("mdui_defer", V_MDUW, 1'b1);
      hz.mdu_done = 1'b1;
      step("mdui_done_int", V_INT, 1'b1);
      hz.mdu_done = 1'b0;  hz.ex_mdu_start = 1'b0;
      step("mdui_drain", V_INT, 1'b1);
      step("mdui_trap", V_TRAP, 1'b1);
      idle();
      step("mdui_run", V_DEF, 1'b1);

      // Interrupt entry with two drain cycles.
      do_reset();
      hz.ex_int_req = 1'b1;
      step("int_c1", V_INT, 1'b1);
      step("int_c2", V_INT, 1'b1);
      step("int_trap", V_TRAP, 1'b1);
      hz.ex_int_req = 1'b0;
      step("int_run", V_DEF, 1'b1);
      chk("int_stall_cnt", 32'(hz.stall_cycles), 32'd2);

      // Memory wait of three cycles, released on the fourth.
      do_reset();
      hz.mem_req = 1'b1;
      for (int k = 0; k < 3; k++) step("mem_wait", V_MEM, 1'b1);
      hz.dmem_ready = 1'b1;
      step("mem_release", V_DEF, 1'b1);
      idle();
      step("mem_after", V_DEF, 1'b1);
      chk("mem_stall_cnt", 32'(hz.stall_cycles), 32'd3);

      // Memory timeout: fault pulse on the fourth wait cycle, then a fresh wait.
      do_reset();
      hz.mem_req = 1'b1;
      for (int k = 0; k < 3; k++) step("tmo_wait", V_MEM, 1'b1);
      step("tmo_fault", V_FLT, 1'b1);
      step("tmo_rewait", V_MEM, 1'b1);
      chk("tmo_stall_cnt", 32'(hz.stall_cycles), 32'd4);

      // Reset during interrupt entry abandons it.
      do_reset();
      hz.ex_int_req = 1'b1;
      step("rint_c1", V_INT, 1'b1);
      rst = 1'b1;
      step("rint_rst", V_RST, 1'b1);
      rst = 1'b0;  hz.ex_int_req = 1'b0;
      chk("rint_stall_cnt", 32'(hz.stall_cycles), 32'd0);
      step("rint_run", V_DEF, 1'b1);
      step("rint_run2", V_DEF, 1'b1);

      // Stall counter saturates at all-ones.
      do_reset();
      hz.ex_mdu_start = 1'b1;
      step("sat_start", V_MDU, 1'b1);
      for (int k = 0; k < 70; k++) step("sat_wait", V_MDUW, 1'b0);
      chk("sat_stall_cnt", 32'(hz.stall_cycles), 32'd63);
      hz.mdu_done = 1'b1;
      step("sat_done", V_DEF, 1'b1);

      // Randomized traffic against the model.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         r = $urandom;
         rst = ($urandom_range(0, 199) == 0);
         set_in(5'(r[1:0]), 5'(r[3:2]), 5'(r[5:4]), r[6],
                (r[9:7] == 3'd0) ? r[12:10] : 3'd0,
                (r[16:13] == 4'd0), (r[20:17] == 4'd0), (r[22:21] == 2'd0),
                (r[24:23] == 2'd0), r[25]);
         step("rnd", V_DEF, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
